// File: rtl/wb_stream_loader.sv
// Purpose: Wishbone master loading program BRAM from a framed byte stream (addr, count, BE words).
// Latency: last byte of a word at edge t raises cyc/stb from t+1; best case 5 cycles per word.
// Backpressure: rx_ready_o low while a write waits for ack and in DONE; optional checksum via WB_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps

module wb_stream_loader #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        ST_HDR,
        ST_DATA,
        ST_WRITE,
`ifdef WB_LOADER_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_DONE
    } state_t;

    // State entered once the payload (or an empty header) has been consumed.
`ifdef WB_LOADER_CHECKSUM_EN
    localparam state_t ST_END = ST_CSUM;
`else
    localparam state_t ST_END = ST_DONE;
`endif

    // Last timeout count value; reaching it without ack aborts the frame.
    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [2:0]    hdr_cnt_q;
    logic [1:0]    byte_cnt_q;
    logic [31:2]   adr_q;      // word address; byte offset bits are always zero
    logic [31:0]   dat_q;
    logic [15:0]   cnt_q;      // words still to write
    logic [7:0]    to_cnt_q;
    logic          err_q;
    logic          rx_fire;
    logic [15:0]   hdr_n;
`ifdef WB_LOADER_CHECKSUM_EN
    logic [7:0]    csum_q;
`endif

    assign rx_fire  = rx_valid_i & rx_ready_o;
    assign hdr_n    = {cnt_q[7:0], rx_data_i};
    assign wb_adr_o = {adr_q, 2'b00};
    assign wb_dat_o = dat_q;
    assign err_o    = err_q;

    // State register; reset drops cyc/stb asynchronously through the state decode.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_HDR;
        else       state_q <= state_d;
    end

    // Next-state and Moore outputs decoded from the current state.
    always_comb begin
        state_d    = state_q;
        rx_ready_o = 1'b0;
        wb_cyc_o   = 1'b0;
        wb_stb_o   = 1'b0;
        wb_we_o    = 1'b0;
        wb_sel_o   = 4'h0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            ST_HDR: begin
                rx_ready_o = 1'b1;
                busy_o     = (hdr_cnt_q != 3'd0);
                if (rx_valid_i && hdr_cnt_q == 3'd5)
                    state_d = (hdr_n == 16'd0) ? ST_END : ST_DATA;
            end
            ST_DATA: begin
                rx_ready_o = 1'b1;
                busy_o     = 1'b1;
                if (rx_valid_i && byte_cnt_q == 2'd3)
                    state_d = ST_WRITE;
            end
            ST_WRITE: begin
                busy_o   = 1'b1;
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_we_o  = 1'b1;
                wb_sel_o = 4'hF;
                if (wb_ack_i)
                    state_d = (cnt_q == 16'd1) ? ST_END : ST_DATA;
                else if (to_cnt_q == TO_LAST)
                    state_d = ST_HDR;
            end
`ifdef WB_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                rx_ready_o = 1'b1;
                busy_o     = 1'b1;
                if (rx_valid_i)
                    state_d = (rx_data_i == csum_q) ? ST_DONE : ST_HDR;
            end
`endif
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_HDR;
            end
            default: state_d = ST_HDR;
        endcase
    end

    // Header parsing, word packing, address/count advance, ack timeout and error flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hdr_cnt_q  <= 3'd0;
            byte_cnt_q <= 2'd0;
            adr_q      <= '0;
            dat_q      <= 32'd0;
            cnt_q      <= 16'd0;
            to_cnt_q   <= 8'd0;
            err_q      <= 1'b0;
`ifdef WB_LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            case (state_q)
                ST_HDR: if (rx_fire) begin
                    if (hdr_cnt_q == 3'd0) err_q <= 1'b0;
                    case (hdr_cnt_q)
                        3'd0:    adr_q[31:24] <= rx_data_i;
                        3'd1:    adr_q[23:16] <= rx_data_i;
                        3'd2:    adr_q[15:8]  <= rx_data_i;
                        3'd3:    adr_q[7:2]   <= rx_data_i[7:2];
                        default: cnt_q        <= {cnt_q[7:0], rx_data_i};
                    endcase
                    hdr_cnt_q  <= (hdr_cnt_q == 3'd5) ? 3'd0 : hdr_cnt_q + 3'd1;
                    byte_cnt_q <= 2'd0;
`ifdef WB_LOADER_CHECKSUM_EN
                    csum_q <= (hdr_cnt_q == 3'd0) ? rx_data_i : (csum_q ^ rx_data_i);
`endif
                end
                ST_DATA: if (rx_fire) begin
                    dat_q      <= {dat_q[23:0], rx_data_i};
                    byte_cnt_q <= byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) to_cnt_q <= 8'd0;
`ifdef WB_LOADER_CHECKSUM_EN
                    csum_q <= csum_q ^ rx_data_i;
`endif
                end
                ST_WRITE: begin
                    if (wb_ack_i) begin
                        adr_q <= adr_q + 30'd1;
                        cnt_q <= cnt_q - 16'd1;
                    end else if (to_cnt_q == TO_LAST) begin
                        err_q <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + 8'd1;
                    end
                end
`ifdef WB_LOADER_CHECKSUM_EN
                ST_CSUM: if (rx_fire && rx_data_i != csum_q) err_q <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stream_loader.sv
// Purpose: directed self-checking bench for wb_stream_loader with a Wishbone slave model.
// Latency: slave acks after a programmable number of stb cycles (or never).
// Backpressure: byte source holds each byte until rx_ready_o; valid may stay high across writes.
`timescale 1ns/1ps

module tb_wb_stream_loader;

    localparam int NEVER = -1;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i;
    logic        busy_o, done_o, err_o;

    always #5 clk_i = ~clk_i;

    wb_stream_loader #(.ACK_TIMEOUT(8)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_ack_i   (wb_ack_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Slave model and protocol monitor, all sampled on the falling edge.
    int          ack_delay  = 0;
    int          stb_cycles = 0;
    int          last_run   = 0;
    int          done_cnt   = 0;
    int          stb_total  = 0;
    int          ready_viol = 0;
    int          bus_viol   = 0;
    logic [31:0] wr_adr[$];
    logic [31:0] wr_dat[$];

    initial begin
        wb_ack_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (done_o) done_cnt++;
            if (wb_stb_o) stb_total++;
            if ((wb_stb_o && rx_ready_o) || (!wb_stb_o && !rx_ready_o && !done_o)) ready_viol++;
            if (wb_stb_o) begin
                if (wb_sel_o != 4'hF || !wb_we_o || !wb_cyc_o) bus_viol++;
            end else if (wb_sel_o != 4'h0 || wb_we_o || wb_cyc_o) begin
                bus_viol++;
            end
            if (wb_ack_i) begin
                wb_ack_i = 1'b0;
            end else if (wb_stb_o) begin
                if (ack_delay >= 0 && stb_cycles == ack_delay) begin
                    wb_ack_i = 1'b1;
                    wr_adr.push_back(wb_adr_o);
                    wr_dat.push_back(wb_dat_o);
                    stb_cycles = 0;
                end else begin
                    stb_cycles++;
                end
            end else begin
                if (stb_cycles > 0) last_run = stb_cycles;
                stb_cycles = 0;
            end
        end
    end

    // Frame builder and byte source.
    logic [7:0] fb[$];
    int         gap = 1;

    task automatic fb_hdr(input logic [31:0] base, input logic [15:0] n);
        fb.delete();
        fb.push_back(base[31:24]);
        fb.push_back(base[23:16]);
        fb.push_back(base[15:8]);
        fb.push_back(base[7:0]);
        fb.push_back(n[15:8]);
        fb.push_back(n[7:0]);
    endtask

    task automatic fb_word(input logic [31:0] w);
        fb.push_back(w[31:24]);
        fb.push_back(w[23:16]);
        fb.push_back(w[15:8]);
        fb.push_back(w[7:0]);
    endtask

    task automatic fb_csum(input logic [7:0] corrupt);
`ifdef WB_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        foreach (fb[i]) x = x ^ fb[i];
        fb.push_back(x ^ corrupt);
`else
        if (corrupt != 8'h00) fb.push_back(corrupt);
`endif
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        if (gap != 0) begin
            rx_valid_i = 1'b0;
            @(negedge clk_i);
        end
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        while (!rx_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) chk("rx_ready_wait", {31'd0, rx_ready_o}, 32'd1);
        @(negedge clk_i);
    endtask

    task automatic send_range(input int from, input int upto);
        for (int i = from; i < upto; i++) send_byte(fb[i]);
        rx_valid_i = 1'b0;
    endtask

    task automatic settle();
        repeat (20) @(negedge clk_i);
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        if (wr_adr.size() == 0) begin
            chk("wr_missing", 32'd0, 32'd1);
        end else begin
            chk("wr_adr", wr_adr.pop_front(), a);
            chk("wr_dat", wr_dat.pop_front(), d);
        end
    endtask

    task automatic expect_no_more_wr();
        chk("wr_extra", wr_adr.size(), 32'd0);
    endtask

    // Safety net so the run always ends.
    initial begin
        #500us;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int d0;
    int s0;

    initial begin
        rst_i      = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        repeat (3) @(negedge clk_i);

        chk("rst_cyc",   {31'd0, wb_cyc_o},   32'd0);
        chk("rst_stb",   {31'd0, wb_stb_o},   32'd0);
        chk("rst_we",    {31'd0, wb_we_o},    32'd0);
        chk("rst_sel",   {28'd0, wb_sel_o},   32'd0);
        chk("rst_adr",   wb_adr_o,            32'd0);
        chk("rst_dat",   wb_dat_o,            32'd0);
        chk("rst_busy",  {31'd0, busy_o},     32'd0);
        chk("rst_done",  {31'd0, done_o},     32'd0);
        chk("rst_err",   {31'd0, err_o},      32'd0);
        chk("rst_ready", {31'd0, rx_ready_o}, 32'd1);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Two-word load, single-cycle ack.
        ack_delay = 0; gap = 1; d0 = done_cnt;
        fb_hdr(32'h0000_0100, 16'd2); fb_word(32'hDEAD_BEEF); fb_word(32'h0102_0304); fb_csum(8'h00);
        send_byte(fb[0]);
        chk("busy_hdr", {31'd0, busy_o}, 32'd1);
        send_range(1, 10);
        chk("stb_after_word", {31'd0, wb_stb_o}, 32'd1);
        chk("adr_in_write", wb_adr_o, 32'h0000_0100);
        chk("dat_in_write", wb_dat_o, 32'hDEAD_BEEF);
        send_range(10, fb.size());
        settle();
        expect_wr(32'h0000_0100, 32'hDEAD_BEEF);
        expect_wr(32'h0000_0104, 32'h0102_0304);
        expect_no_more_wr();
        chk("t1_done", done_cnt - d0, 32'd1);
        chk("t1_err", {31'd0, err_o}, 32'd0);
        chk("t1_busy", {31'd0, busy_o}, 32'd0);

        // Empty frame: done pulse straight after the header, no bus cycle.
        d0 = done_cnt; s0 = stb_total;
        fb_hdr(32'h0000_2000, 16'd0); fb_csum(8'h00);
        send_range(0, fb.size());
        chk("n0_done_now", {31'd0, done_o}, 32'd1);
        settle();
        chk("n0_done", done_cnt - d0, 32'd1);
        chk("n0_no_stb", stb_total - s0, 32'd0);
        expect_no_more_wr();

        // Slave never acks: abort after 8 strobe cycles.
        ack_delay = NEVER; d0 = done_cnt;
        fb_hdr(32'h0000_0040, 16'd1); fb_word(32'h1122_3344);
        send_range(0, fb.size());
        settle();
        chk("to_run", last_run, 32'd8);
        chk("to_err", {31'd0, err_o}, 32'd1);
        chk("to_done", done_cnt - d0, 32'd0);
        chk("to_busy", {31'd0, busy_o}, 32'd0);
        expect_no_more_wr();

        // Next frame clears the error on its first byte and loads normally.
        ack_delay = 1; d0 = done_cnt;
        fb_hdr(32'h0000_0200, 16'd1); fb_word(32'hCAFE_BABE); fb_csum(8'h00);
        send_byte(fb[0]);
        chk("err_clear", {31'd0, err_o}, 32'd0);
        send_range(1, fb.size());
        settle();
        expect_wr(32'h0000_0200, 32'hCAFE_BABE);
        expect_no_more_wr();
        chk("t3b_done", done_cnt - d0, 32'd1);

        // Valid held high through a 3-word frame, ack after 3 extra cycles.
        gap = 0; ack_delay = 3; d0 = done_cnt; s0 = ready_viol;
        fb_hdr(32'h0000_0300, 16'd3);
        fb_word(32'h1020_3040); fb_word(32'h5060_7080); fb_word(32'h90A0_B0C0); fb_csum(8'h00);
        send_range(0, fb.size());
        settle();
        expect_wr(32'h0000_0300, 32'h1020_3040);
        expect_wr(32'h0000_0304, 32'h5060_7080);
        expect_wr(32'h0000_0308, 32'h90A0_B0C0);
        expect_no_more_wr();
        chk("hold_ready", ready_viol - s0, 32'd0);
        chk("hold_done", done_cnt - d0, 32'd1);

        // Address wrap and ignored base offset bits.
        gap = 1; ack_delay = 0; d0 = done_cnt;
        fb_hdr(32'hFFFF_FFFC, 16'd2); fb_word(32'h0101_0101); fb_word(32'h0202_0202); fb_csum(8'h00);
        send_range(0, fb.size());
        settle();
        expect_wr(32'hFFFF_FFFC, 32'h0101_0101);
        expect_wr(32'h0000_0000, 32'h0202_0202);
        fb_hdr(32'h0000_0103, 16'd1); fb_word(32'hA5A5_A5A5); fb_csum(8'h00);
        send_range(0, fb.size());
        settle();
        expect_wr(32'h0000_0100, 32'hA5A5_A5A5);
        expect_no_more_wr();
        chk("wrap_done", done_cnt - d0, 32'd2);
        chk("wrap_err", {31'd0, err_o}, 32'd0);

        // Reset in the middle of a write.
        ack_delay = NEVER;
        fb_hdr(32'h0000_0400, 16'd2); fb_word(32'h1234_5678);
        send_range(0, 10);
        chk("stb_pre_rst", {31'd0, wb_stb_o}, 32'd1);
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("rst_async_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_async_stb", {31'd0, wb_stb_o}, 32'd0);
        @(negedge clk_i);
        chk("mrst_busy",  {31'd0, busy_o},     32'd0);
        chk("mrst_err",   {31'd0, err_o},      32'd0);
        chk("mrst_adr",   wb_adr_o,            32'd0);
        chk("mrst_dat",   wb_dat_o,            32'd0);
        chk("mrst_sel",   {28'd0, wb_sel_o},   32'd0);
        chk("mrst_we",    {31'd0, wb_we_o},    32'd0);
        chk("mrst_done",  {31'd0, done_o},     32'd0);
        chk("mrst_ready", {31'd0, rx_ready_o}, 32'd1);
        rst_i = 1'b0;
        @(negedge clk_i);
        ack_delay = 0; d0 = done_cnt;
        fb_hdr(32'h0000_0500, 16'd1); fb_word(32'h0BAD_F00D); fb_csum(8'h00);
        send_range(0, fb.size());
        settle();
        expect_wr(32'h0000_0500, 32'h0BAD_F00D);
        expect_no_more_wr();
        chk("post_rst_done", done_cnt - d0, 32'd1);

`ifdef WB_LOADER_CHECKSUM_EN
        // Wrong checksum byte: write stands, error set, no done pulse.
        ack_delay = 0; d0 = done_cnt;
        fb_hdr(32'h0000_0600, 16'd1); fb_word(32'h1111_1111); fb_csum(8'h5A);
        send_range(0, fb.size());
        settle();
        expect_wr(32'h0000_0600, 32'h1111_1111);
        expect_no_more_wr();
        chk("csum_err", {31'd0, err_o}, 32'd1);
        chk("csum_done", done_cnt - d0, 32'd0);
`endif

        chk("ready_viol", ready_viol, 32'd0);
        chk("bus_viol", bus_viol, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stream_loader.md
# wb_stream_loader

Wishbone master that fills the on-chip program BlockRAM from a byte stream (UART receiver or debug link) before the LM32 leaves reset. It parses a small header (base address and word count), packs payload bytes into 32-bit big-endian words, and issues one single-word Wishbone write per word, waiting for the slave ack. It sits directly upstream of the BRAM's Wishbone slave port, through the bus mux that selects loader versus CPU.

## Interface

- ACK_TIMEOUT, 255: cycles a write may wait for ack before aborting; 8-bit counter.
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- rx_data_i  in  8  incoming byte.
- rx_valid_i  in  1  byte present; consumed on a cycle with rx_valid_i & rx_ready_o.
- rx_ready_o  out  1  loader can accept a byte.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe.
- wb_we_o  out  1  write enable; 1 whenever stb is high.
- wb_adr_o  out  32  byte address; bits [1:0] always 0.
- wb_dat_o  out  32  write data.
- wb_sel_o  out  4  byte lanes; always 4'hF during a cycle.
- wb_ack_i  in  1  slave acknowledge.
- busy_o  out  1  a transfer (header started) is in progress.
- done_o  out  1  one-cycle pulse on successful completion.
- err_o  out  1  sticky error; cleared when the next header's first byte is accepted.

## Operation

- Frame: 4 address bytes (MSB first), 2 count bytes N (MSB first), then 4·N data bytes. Word k is written to base + 4k with its first byte on [31:24]. Base bits [1:0] are ignored (forced 0).
- States: HDR, DATA, WRITE, CSUM (only with the checksum feature), DONE.
- HDR: rx_ready_o=1; 3-bit byte counter 0..5. After byte 5: N=0 → DONE (or CSUM), else DATA.
- DATA: rx_ready_o=1; shift bytes into the word register. The 4th byte moves to WRITE.
- WRITE: rx_ready_o=0; cyc/stb/we=1; adr and dat are held stable. On wb_ack_i, cyc/stb drop at the next edge, the address advances by 4, and the remaining count is decremented. If the count reaches 0, go to DONE (or CSUM); otherwise go to DATA.
- Ack timeout: the counter clears on entering WRITE. If it reaches ACK_TIMEOUT without ack, set err_o, drop cyc/stb, and return to HDR. No done pulse.
- DONE: done_o=1 for one cycle, then HDR. busy_o=0 in HDR before the first byte and in DONE.
- Address arithmetic is 32-bit and wraps modulo 2^32 without error.
- rx_valid_i while rx_ready_o=0 is not consumed; the upstream source holds the byte.

## Timing

- Reset values: state HDR; wb_cyc_o, wb_stb_o, wb_we_o, busy_o, done_o, err_o = 0; wb_adr_o, wb_dat_o = 0; wb_sel_o = 0 outside WRITE.
- rx_ready_o is combinational from state.
- The last byte of a word accepted at edge t gives cyc/stb high from t+1.
- Ack sampled high at edge t gives stb low after t. The next payload byte can be accepted at edge t+1.
- Best case is 5 cycles per word with a one-cycle-ack slave. The BRAM slave needs stb held until ack, and the loader never holds stb past ack.
- Reset asserted mid-write: cyc/stb fall immediately (asynchronously); the partial frame is discarded.

## Configuration

- WB_LOADER_CHECKSUM_EN defined: after the payload (or after the header when N=0), one extra byte is expected in CSUM. It must equal the XOR of all 6 header bytes and 4·N payload bytes. On mismatch, err_o=1 and no done pulse (writes already performed stand). On match, go to DONE.
- WB_LOADER_CHECKSUM_EN undefined: there is no CSUM state. DONE follows the last ack directly and the frame carries no trailing byte.

## Test plan

- Header 00 00 01 00, 00 02, data DE AD BE EF 01 02 03 04, ack one cycle after stb → writes 0x100←0xDEADBEEF, 0x104←0x01020304; sel=F; one done pulse; err_o=0.
- Header with N=0 (checksum build: trailing byte = XOR of header) → no bus cycle; done_o pulses after the last header byte.
- Slave never acks, ACK_TIMEOUT=8 → stb drops after 8 cycles in WRITE; err_o=1, no done pulse. The next frame's first byte clears err_o and a normal load succeeds.
- rx_valid_i held high continuously during a 3-word frame, ack delayed by 3 cycles → no byte is lost or duplicated; rx_ready_o=0 exactly during each WRITE.
- Base 0xFFFF_FFFC, N=2 → second write goes to 0x0000_0000. Base 0x0000_0103 → first write goes to 0x100.
- Reset asserted during WRITE → cyc/stb go 0 immediately; after release, state is HDR with all outputs at their reset values. Checksum build only: a wrong checksum byte gives err_o=1 and no done pulse.
